// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) / byte-substitution helpers.
// S-box values are derived from the field inverse plus the affine map rather than stored as tables.
package aes_pkg;

    typedef logic [0:127] aes_state_t;

    localparam logic [7:0] AES_RC_POLY = 8'h1b;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} eng_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RC_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        logic [7:0] e;
        r  = 8'h01;
        sq = a;
        e  = 8'hfe;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, sq);
            sq = gmul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int unsigned k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
        return o;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int unsigned k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        return o;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
        return o;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
        return o;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[32*c+8 +: 8]  = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational single-round AES datapath, forward and (optionally) inverse.
module aes_round_dp
    import aes_pkg::*;
#(
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  logic [0:127] state,
    input  logic [0:127] key,
    input  logic         mode,
    input  logic         last_round,
    output logic [0:127] next_state
);

    aes_state_t enc_sr;
    aes_state_t enc_out;

    always_comb begin
        enc_sr  = shift_rows(sub_bytes(state));
        enc_out = (last_round ? enc_sr : mix_columns(enc_sr)) ^ key;
    end

    // Inverse round uses the straight (non-equivalent) ordering: key add precedes invMixColumns.
    if (ENABLE_DECRYPT) begin : g_dec
        aes_state_t dec_ark;
        aes_state_t dec_out;
        always_comb begin
            dec_ark = inv_sub_bytes(inv_shift_rows(state)) ^ key;
            dec_out = last_round ? dec_ark : inv_mix_columns(dec_ark);
        end
        assign next_state = mode ? dec_out : enc_out;
    end else begin : g_enc
        logic mode_unused;
        assign mode_unused = mode;
        assign next_state  = enc_out;
    end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES engine: one round per clock, round keys fetched by index from external RAM.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS     = 10,
    parameter bit          ENABLE_DECRYPT = 1'b1,
    parameter int unsigned RIDX_W         = $clog2(NUM_ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:127]      in_data,
    input  logic              in_mode,
    output logic [RIDX_W-1:0] key_idx,
    input  logic [0:127]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:127]      out_data,
    output logic              busy
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS);
    localparam logic [RIDX_W-1:0] PENULT   = RIDX_W'(NUM_ROUNDS - 1);

    eng_state_t        fsm;
    aes_state_t        st;
    aes_state_t        rnd_next;
    logic [RIDX_W-1:0] rnd;
    logic              mode_q;
    logic              dec;
    logic              accept;
    logic              last_round;

    assign dec        = ENABLE_DECRYPT && mode_q;
    assign in_ready   = (fsm == IDLE) || (fsm == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (fsm == INIT) || (fsm == ROUND) || (fsm == FINAL);
    assign last_round = (fsm == FINAL);

    always_comb begin
        key_idx = '0;
        case (fsm)
            INIT:    key_idx = dec ? LAST_IDX : '0;
            ROUND:   key_idx = dec ? LAST_IDX - rnd : rnd;
            FINAL:   key_idx = dec ? '0 : LAST_IDX;
            default: key_idx = '0;
        endcase
    end

    aes_round_dp #(
        .ENABLE_DECRYPT(ENABLE_DECRYPT)
    ) u_dp (
        .state     (st),
        .key       (round_key),
        .mode      (dec),
        .last_round(last_round),
        .next_state(rnd_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            st        <= '0;
            rnd       <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        st     <= in_data;
                        mode_q <= in_mode & ENABLE_DECRYPT;
                        fsm    <= INIT;
                    end
                end
                INIT: begin
                    st  <= st ^ round_key;
                    rnd <= RIDX_W'(1);
                    fsm <= ROUND;
                end
                ROUND: begin
                    st <= rnd_next;
                    if (rnd == PENULT) begin
                        rnd <= '0;
                        fsm <= FINAL;
                    end else begin
                        rnd <= rnd + 1'b1;
                    end
                end
                FINAL: begin
                    out_data  <= rnd_next;
                    out_valid <= 1'b1;
                    fsm       <= DONE;
                end
                DONE: begin
                    // Output transfer and a fresh accept may share this edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            st     <= in_data;
                            mode_q <= in_mode & ENABLE_DECRYPT;
                            fsm    <= INIT;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative, multi-cycle AES cipher core. Executes one full round per clock on a 128-bit state.
- Generalises the existing combinational subBytes/shiftRows/mixColumns chain into a sequenced engine.
- Adds round counting, a final round without mixColumns, a decrypt mode, and ready/valid flow control.
- Sits between the USB packet buffer, which supplies input blocks, and the key-schedule RAM, which supplies round keys by index.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Legal values: 10 (AES-128), 12 (AES-192), 14 (AES-256).
- ENABLE_DECRYPT, 1, when 0 the inverse datapath is removed and mode is ignored (always encrypt).
- RIDX_W, $clog2(NUM_ROUNDS+1), width of the round-key index.

Ports:
- clk  in  1  system clock. Rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block this cycle.
- in_data  in  [0:127]  input state. Byte k is bits [8k:8k+7]. Column-major: bytes 0..3 form column 0.
- in_mode  in  1  0 = encrypt, 1 = decrypt. Sampled only on accept.
- key_idx  out  RIDX_W  round-key index requested this cycle.
- round_key  in  [0:127]  key for key_idx, combinationally valid in the same cycle.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  [0:127]  ciphertext or plaintext.
- busy  out  1  high in INIT, ROUND and FINAL.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, key_idx=0, busy=0, round counter=0, mode register=0.
- Reset mid-operation: the block in flight is discarded; no partial output is ever presented.
- Handshakes: accept occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accept is allowed in the same cycle the output transfers.
- FSM states and transitions:
  - IDLE: on accept, capture in_data and in_mode, then go to INIT.
  - INIT (1 cycle): state <= in_state ^ round_key. key_idx = 0 for encrypt, NUM_ROUNDS for decrypt. Then go to ROUND.
  - ROUND: cycles r = 1..NUM_ROUNDS-1.
    - Encrypt: state <= mixColumns(shiftRows(subBytes(state))) ^ key[r].
    - Decrypt: state <= invMixColumns(invSubBytes(invShiftRows(state)) ^ key[NUM_ROUNDS-r]).
    - Go to FINAL after r = NUM_ROUNDS-1.
  - FINAL (1 cycle): the same round with mixColumns / invMixColumns omitted. Key index is NUM_ROUNDS (encrypt) or 0 (decrypt). Result goes to out_data; out_valid <= 1; go to DONE.
  - DONE: hold out_data and out_valid stable while out_ready=0.
    - On transfer with no new accept: out_valid <= 0, go to IDLE.
    - On transfer with a simultaneous accept: go to INIT.
- Latency: accept at edge t gives out_valid high after edge t+NUM_ROUNDS+1. Throughput is one block per NUM_ROUNDS+2 cycles with out_ready held high.
- key_idx is driven combinationally from the state and round counter. In IDLE and DONE it is 0. Key is registered nowhere inside the engine.
- GF(2^8) arithmetic: xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0). invMixColumns uses the multipliers {0e,0b,0d,09}.
- If ENABLE_DECRYPT=0, in_mode is ignored and no inverse logic is synthesised.
- in_valid asserted while busy is not accepted and has no effect. The upstream holds the block.

Decomposition:
- aes_pkg holds:
  - typedef aes_state_t (logic [0:127]); constant AES_RC_POLY = 8'h1b.
  - functions xtime, gmul, sbox, inv_sbox; NR_AES128 / NR_AES192 / NR_AES256.
  - typedef enum eng_state_t {IDLE, INIT, ROUND, FINAL, DONE}.
- One sub-module, aes_round_dp: combinational one-round datapath.
  - Inputs: state, key, mode, last_round. Output: next state.
  - Instantiates the existing subBytes, shiftRows and mixColumns, plus the inverse functions from aes_pkg.
- The engine module holds the FSM, round counter, and state and output registers.

Test Plan:
- FIPS-197 App. B encrypt, NUM_ROUNDS=10, key 2b7e151628aed2a6abf7158809cf4f3c, schedule from the bench model.
  - in 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32, 11 cycles after accept.
  - Internal state after INIT = 193de3bea0f4e22b9ac68d2ae9f84808; after round 1 = a49c7ff2689f352b6b5bea43026a5049.
- Decrypt same key, in 3925841d02dc09fbdc118597196a0b32, mode=1 -> out 3243f6a8885a308d313198a2e0370734. key_idx sequence 10,9,...,0.
- NUM_ROUNDS=14 (FIPS App. C.3), key 000102...1f, in 00112233445566778899aabbccddeeff -> out 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
- Back-pressure: out_ready=0 for 5 cycles -> out_data/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> transfer and accept in the same cycle, next result after another 11 cycles.
- in_valid held high during ROUND -> no accept and the result is unchanged. rst asserted during round 5 -> next cycle IDLE, out_valid=0, in_ready=1, and no output is ever emitted for that block.
- ENABLE_DECRYPT=0 with in_mode=1 -> encrypt result 3925841d02dc09fbdc118597196a0b32.
